// File: rtl/hub75_rx_capture.sv
// HUB75 receive monitor: synchronizes the panel link, captures rows into a ping-pong buffer.
// Optional OE on-time measurement is enabled by defining HUB75_RX_OE_MEAS_EN.
module hub75_rx_capture #(
  parameter int NUM_BITS    = 192,
  parameter int SYNC_STAGES = 2,
  parameter int OE_CNT_W    = 16
) (
  input  logic                        CLK_INT,
  input  logic                        rst,
  input  logic                        CLK_M,
  input  logic                        LAT,
  input  logic                        OE,
  input  logic                        A,
  input  logic                        B,
  input  logic                        R1,
  input  logic                        G1,
  input  logic                        B1,
  input  logic                        R2,
  input  logic                        G2,
  input  logic                        B2,
  input  logic [$clog2(NUM_BITS)-1:0] rd_addr,
  output logic [5:0]                  rd_data,
  output logic                        row_valid,
  output logic [1:0]                  row_addr,
  output logic [OE_CNT_W-1:0]         oe_cycles,
  output logic                        err_short,
  output logic                        err_long,
  output logic                        err_addr
);

  localparam int AW = $clog2(NUM_BITS);
  localparam int CW = $clog2(NUM_BITS + 2);
  localparam logic [CW-1:0] NB_C  = CW'(NUM_BITS);
  localparam logic [CW-1:0] MAX_C = CW'(NUM_BITS + 1);
  localparam logic [AW:0]   NB_RD = (AW + 1)'(NUM_BITS);
  // {CLK_M, LAT, OE, A, B, data[5:0]}: idle link has CLK_M and OE high
  localparam logic [10:0]   SYNC_RST = 11'b101_0000_0000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DISP  = 2'd2;

  logic [10:0]   sync_r [SYNC_STAGES];
  logic [10:0]   link_s;
  logic          clk_s, lat_s, oe_s;
  logic [1:0]    ab_s;
  logic [5:0]    data_s;
  logic          clk_prev_r, lat_prev_r;
  logic [1:0]    ab_prev_r;
  logic          clk_rise_s, lat_rise_s;
  logic [1:0]    state_r, state_nxt_s;
  logic [CW-1:0] bit_cnt_r, bit_cnt_nxt_s, cnt_inc_s;
  logic          commit_s, short_s, long_s, wr_en_s;
  logic          bank_sel_r;
  logic [5:0]    bank_r [2][NUM_BITS];

  // Input synchronizer chain, identical depth for data and strobes
  always_ff @(posedge CLK_INT) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= SYNC_RST;
    end else begin
      sync_r[0] <= {CLK_M, LAT, OE, A, B, R1, G1, B1, R2, G2, B2};
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign link_s     = sync_r[SYNC_STAGES-1];
  assign clk_s      = link_s[10];
  assign lat_s      = link_s[9];
  assign oe_s       = link_s[8];
  assign ab_s       = link_s[7:6];
  assign data_s     = link_s[5:0];
  assign clk_rise_s = clk_s & ~clk_prev_r;
  assign lat_rise_s = lat_s & ~lat_prev_r;
  assign wr_en_s    = clk_rise_s && (bit_cnt_r < NB_C);

  // Next-state: a coincident bit is counted before the latch is judged
  always_comb begin
    cnt_inc_s     = bit_cnt_r;
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    commit_s      = 1'b0;
    short_s       = 1'b0;
    long_s        = 1'b0;
    if (clk_rise_s && (bit_cnt_r != MAX_C)) cnt_inc_s = bit_cnt_r + CW'(1);
    else                                     cnt_inc_s = bit_cnt_r;
    bit_cnt_nxt_s = cnt_inc_s;
    case (state_r)
      ST_IDLE: begin
        if (clk_rise_s) state_nxt_s = ST_SHIFT;
        else            state_nxt_s = ST_IDLE;
      end
      ST_SHIFT, ST_DISP: begin
        if (lat_rise_s) begin
          state_nxt_s   = ST_DISP;
          bit_cnt_nxt_s = '0;
          if (cnt_inc_s == NB_C)     commit_s = 1'b1;
          else if (cnt_inc_s < NB_C) short_s  = 1'b1;
          else                       long_s   = 1'b1;
        end else if (clk_rise_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        bit_cnt_nxt_s = '0;
      end
    endcase
  end

  // Control state, edge history and registered status outputs
  always_ff @(posedge CLK_INT) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= '0;
      bank_sel_r <= 1'b0;
      clk_prev_r <= 1'b1;
      lat_prev_r <= 1'b0;
      ab_prev_r  <= 2'b00;
      row_valid  <= 1'b0;
      row_addr   <= 2'b00;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      err_addr   <= 1'b0;
      rd_data    <= 6'b0;
    end else begin
      state_r    <= state_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      bank_sel_r <= bank_sel_r ^ commit_s;
      clk_prev_r <= clk_s;
      lat_prev_r <= lat_s;
      ab_prev_r  <= ab_s;
      row_valid  <= commit_s;
      row_addr   <= commit_s ? ab_s : row_addr;
      err_short  <= short_s;
      err_long   <= long_s;
      err_addr   <= (ab_s != ab_prev_r) && !oe_s;
      rd_data    <= ({1'b0, rd_addr} < NB_RD) ? bank_r[bank_sel_r][rd_addr] : 6'b0;
    end
  end

  // Row storage; the shift side always fills the bank not on display
  always_ff @(posedge CLK_INT) begin
    if (wr_en_s) bank_r[~bank_sel_r][bit_cnt_r[AW-1:0]] <= data_s;
  end

`ifdef HUB75_RX_OE_MEAS_EN
  logic                oe_prev_r;
  logic [OE_CNT_W-1:0] oe_cnt_r;

  // OE-low window counter, published when OE returns high
  always_ff @(posedge CLK_INT) begin
    if (!rst) begin
      oe_prev_r <= 1'b1;
      oe_cnt_r  <= '0;
      oe_cycles <= '0;
    end else begin
      oe_prev_r <= oe_s;
      if (!oe_s && oe_prev_r)            oe_cnt_r <= OE_CNT_W'(1);
      else if (!oe_s && (oe_cnt_r != '1)) oe_cnt_r <= oe_cnt_r + OE_CNT_W'(1);
      else                                oe_cnt_r <= oe_cnt_r;
      if (oe_s && !oe_prev_r) oe_cycles <= oe_cnt_r;
      else                    oe_cycles <= oe_cycles;
    end
  end
`else
  assign oe_cycles = '0;
`endif

endmodule

// File: tb/tb_hub75_rx_capture.sv
// Randomized directed bench for hub75_rx_capture with a row-level reference model.
module tb_hub75_rx_capture;
  localparam int NB   = 192;
  localparam int SYNC = 2;
  localparam int OEW  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, CLK_M, LAT, OE, A, B, R1, G1, B1, R2, G2, B2;
  logic [7:0] rd_addr;
  logic [5:0] rd_data;
  logic row_valid, err_short, err_long, err_addr;
  logic [1:0] row_addr;
  logic [OEW-1:0] oe_cycles;

  hub75_rx_capture #(.NUM_BITS(NB), .SYNC_STAGES(SYNC), .OE_CNT_W(OEW)) dut (
    .CLK_INT(clk), .rst(rst), .CLK_M(CLK_M), .LAT(LAT), .OE(OE), .A(A), .B(B),
    .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
    .rd_addr(rd_addr), .rd_data(rd_data), .row_valid(row_valid), .row_addr(row_addr),
    .oe_cycles(oe_cycles), .err_short(err_short), .err_long(err_long), .err_addr(err_addr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_rv = 0, n_es = 0, n_el = 0, n_ea = 0, last_rv_cyc = 0;

  // reference model state
  logic [5:0] commit_m [NB];
  bit         committed_ok = 1'b0;
  logic [5:0] row_q [$];
  int exp_rv = 0, exp_es = 0, exp_el = 0, exp_ea = 0;
  logic [1:0] exp_row_addr = 2'b00;
`ifdef HUB75_RX_OE_MEAS_EN
  localparam bit OE_MEAS = 1'b1;
`else
  localparam bit OE_MEAS = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (row_valid) begin
      n_rv <= n_rv + 1;
      last_rv_cyc <= cyc;
    end
    if (err_short) n_es <= n_es + 1;
    if (err_long)  n_el <= n_el + 1;
    if (err_addr)  n_ea <= n_ea + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [5:0] d);
    {R1, G1, B1, R2, G2, B2} = d;
    CLK_M = 1'b0;
    tick(2);
    CLK_M = 1'b1;
    tick(2);
    row_q.push_back(d);
  endtask

  task automatic send_row(input int len, input bit rnd);
    logic [5:0] d;
    for (int i = 0; i < len; i++) begin
      if (rnd) d = 6'($urandom);
      else     d = {i[0], 5'b00000};
      pulse(d);
    end
  endtask

  task automatic latch(input logic [1:0] ab);
    int lc;
    bit exact;
    A = ab[1];
    B = ab[0];
    tick(2);
    lc = cyc;
    LAT = 1'b1;
    tick(8);
    LAT = 1'b0;
    tick(4);
    exact = (row_q.size() == NB);
    if (exact) begin
      for (int i = 0; i < NB; i++) commit_m[i] = row_q[i];
      committed_ok = 1'b1;
      exp_rv++;
      exp_row_addr = ab;
    end else if (row_q.size() < NB) begin
      exp_es++;
    end else begin
      exp_el++;
    end
    row_q.delete();
    check("row_valid_count", n_rv, exp_rv);
    check("err_short_count", n_es, exp_es);
    check("err_long_count", n_el, exp_el);
    check("row_addr", {30'd0, row_addr}, {30'd0, exp_row_addr});
    check("err_addr_count", n_ea, exp_ea);
    if (exact) check("row_valid_latency", last_rv_cyc - lc, SYNC + 1);
  endtask

  task automatic rd_check(input int addr);
    logic [5:0] e;
    rd_addr = 8'(addr);
    tick(1);
    e = (addr >= NB) ? 6'b0 : commit_m[addr];
    if (addr >= NB || committed_ok) check("rd_data", {26'd0, rd_data}, {26'd0, e});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_row_valid"}, {31'd0, row_valid}, 32'd0);
    check({tag, "_errs"}, {29'd0, err_short, err_long, err_addr}, 32'd0);
    check({tag, "_row_addr"}, {30'd0, row_addr}, 32'd0);
    check({tag, "_oe_cycles"}, {16'd0, oe_cycles}, 32'd0);
    check({tag, "_rd_data"}, {26'd0, rd_data}, 32'd0);
  endtask

  initial begin
    int lens [6];
    int n1, n2;
    lens = '{190, 191, 192, 192, 193, 194};
    rst = 1'b0; CLK_M = 1'b1; LAT = 1'b0; OE = 1'b1; A = 1'b0; B = 1'b0;
    {R1, G1, B1, R2, G2, B2} = 6'b0;
    rd_addr = 8'd0;
    @(negedge clk);
    tick(4);
    check_zero("reset");
    rst = 1'b1;
    tick(4);

    // exact row with alternating R1
    send_row(NB, 1'b0);
    latch(2'd2);
    rd_check(5);
    check("exact_rd5_const", {26'd0, rd_data}, 32'b100000);
    rd_check(4);
    check("exact_rd4_const", {26'd0, rd_data}, 32'd0);
    rd_check(NB);
    rd_check(255);

    // short row keeps previous bank
    send_row(NB - 1, 1'b1);
    latch(2'd1);
    rd_check(5);
    check("short_keeps_rd5", {26'd0, rd_data}, 32'b100000);

    // long row, then a normal commit
    send_row(NB + 1, 1'b1);
    latch(2'd3);
    rd_check(7);
    send_row(NB, 1'b1);
    latch(2'd0);
    rd_check(0);
    rd_check(NB - 1);

    // randomized rows
    for (int r = 0; r < 4; r++) begin
      send_row(lens[$urandom_range(0, 5)], 1'b1);
      latch(2'($urandom));
      for (int k = 0; k < 3; k++) rd_check($urandom_range(0, 255));
    end

    // address change while OE low, then while OE high
    OE = 1'b0;
    tick(5);
    A = ~A;
    tick(8);
    exp_ea++;
    check("err_addr_oe_low", n_ea, exp_ea);
    OE = 1'b1;
    tick(5);
    A = ~A;
    tick(8);
    check("err_addr_oe_high", n_ea, exp_ea);

    // OE window measurement
    OE = 1'b0;
    tick(2999);
    OE = 1'b1;
    tick(6);
    check("oe_cycles_2999", {16'd0, oe_cycles}, OE_MEAS ? 32'd2999 : 32'd0);

    // window spanning a latch with no bits
    n1 = $urandom_range(20, 200);
    n2 = $urandom_range(20, 200);
    OE = 1'b0;
    tick(n1);
    LAT = 1'b1;
    tick(4);
    LAT = 1'b0;
    tick(n2);
    OE = 1'b1;
    tick(6);
    exp_es++;
    check("oe_cycles_across_lat", {16'd0, oe_cycles}, OE_MEAS ? 32'(n1 + 4 + n2) : 32'd0);
    check("empty_lat_err_short", n_es, exp_es);
    check("empty_lat_no_commit", n_rv, exp_rv);

    // reset in the middle of a row
    send_row(100, 1'b1);
    rst = 1'b0;
    tick(1);
    check_zero("midrow_reset");
    rst = 1'b1;
    row_q.delete();
    committed_ok = 1'b0;
    exp_row_addr = 2'b00;
    tick(4);
    send_row(NB, 1'b1);
    latch(2'd1);
    rd_check(0);
    rd_check(99);
    rd_check(100);
    rd_check(NB - 1);
    rd_check(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hub75_rx_capture.md
Name: hub75_rx_capture

Overview:
- Receiving end of the HUB75 panel link that the LED-matrix driver transmits on.
- Oversamples CLK_M, LAT, OE, A, B and R1/G1/B1/R2/G2/B2 on CLK_INT, and shifts pixel bits into a ping-pong row buffer.
- Commits a row on LAT, reports row address and OE on-time, and flags malformed rows.
- Used as an in-fabric loopback monitor and panel emulator for the sign/traffic-light display path.

Parameters:
- NUM_BITS, 192, pixel clocks per row per channel (NUM_MOD*PIX_MOD).
- SYNC_STAGES, 2, synchronizer depth on all link inputs (minimum 2).
- OE_CNT_W, 16, width of OE on-time counter.

Ports:
- CLK_INT  in  1  sampling clock; must be at least 4x the CLK_M toggle rate.
- rst  in  1  reset: synchronous, active-low.
- CLK_M  in  1  panel shift clock; data is taken on its rising edge.
- LAT  in  1  row latch strobe, active-high.
- OE  in  1  output enable, active-low.
- A, B  in  1 each  row select; row = {A,B}.
- R1, G1, B1, R2, G2, B2  in  1 each  pixel data.
- rd_addr  in  $clog2(NUM_BITS)  read index into the committed row.
- rd_data  out  6  {R1,G1,B1,R2,G2,B2} at rd_addr, registered.
- row_valid  out  1  one-cycle pulse when a complete row commits.
- row_addr  out  2  row select captured at commit.
- oe_cycles  out  OE_CNT_W  OE-low cycle count of the last completed display window.
- err_short, err_long, err_addr  out  1 each  one-cycle error pulses.

Behaviour:
- Synchronizers:
  - All link inputs pass through SYNC_STAGES flops.
  - Reset values: CLK_M=1, LAT=0, OE=1, others 0.
  - Data and control share the same depth, so they stay aligned.
- Edge detect: one extra flop per strobe. clk_rise = ~prev & cur on CLK_M. lat_rise likewise. oe_fall / oe_rise on OE.
- bit_cnt:
  - Width $clog2(NUM_BITS+2).
  - On clk_rise, the 6 data bits are written to write bank entry bit_cnt if bit_cnt<NUM_BITS, and bit_cnt increments.
  - bit_cnt saturates at NUM_BITS+1.
  - Index 0 is the first bit received.
- FSM states and transitions:
  - IDLE: clk_rise -> SHIFT (that bit is stored as index 0).
  - SHIFT: shifting; lat_rise -> evaluate.
    - Exact row (bit_cnt==NUM_BITS): swap banks, latch row_addr={A,B}, pulse row_valid next cycle, -> DISP.
    - bit_cnt<NUM_BITS: pulse err_short, no swap, -> DISP.
    - bit_cnt>NUM_BITS: pulse err_long, no swap, -> DISP.
  - DISP: bit_cnt cleared to 0.
    - clk_rise -> SHIFT, storing index 0 immediately.
    - lat_rise in DISP with no bits -> err_short, stay in DISP.
- Simultaneous clk_rise and lat_rise: the bit is counted first, then the latch is evaluated.
- Latency: row_valid asserts exactly 1 CLK_INT cycle after the cycle lat_rise is detected. row_addr is valid on and after that pulse.
- Read port:
  - rd_data updates one cycle after rd_addr and reads the committed (display) bank only.
  - rd_addr>=NUM_BITS returns 6'b0.
  - Bank contents are don't-care until the first row_valid after reset.
- err_addr: pulse if {A,B} changes while synchronized OE=0.
- Reset mid-row (rst=0 on any edge):
  - FSM -> IDLE, bit_cnt=0, bank select=0.
  - All pulses and error outputs 0, row_addr=0, oe_cycles=0, rd_data=0.
  - Partial row is discarded.

Optional Feature:
- Macro: HUB75_RX_OE_MEAS_EN.
- Defined:
  - Counter clears on oe_fall and increments each cycle OE=0, saturating at all-ones.
  - On oe_rise, the count is copied to oe_cycles.
  - OE low across a lat_rise is still counted as one window.
- Undefined: counter logic is absent and oe_cycles is tied to 0.

Test Plan:
- Exact row: 192 CLK_M pulses carrying R1 = bit index[0] (alternating 0/1), others 0, then LAT with {A,B}=2 -> row_valid one pulse, row_addr=2, rd_addr=5 gives rd_data=6'b100000, rd_addr=4 gives 0.
- Short row: 191 pulses then LAT -> err_short pulse, no row_valid, and rd_data still returns the previously committed row.
- Long row: 193 pulses then LAT -> err_long pulse, no bank swap. A following exact 192-bit row commits normally.
- OE window (macro on): OE low 2999 CLK_INT cycles then high -> oe_cycles=2999. With the macro off -> oe_cycles=0.
- Address glitch: toggle A while OE=0 -> err_addr one pulse. Toggle A while OE=1 -> no pulse.
- Reset mid-row: rst low 1 cycle after 100 bits, then a full 192-bit row plus LAT -> outputs all zero during reset, then row_valid after the full row with correct data.
